// File: rtl/perceptron_array_trainer.sv
// Multi-output perceptron with an on-chip training sequencer and a one-cycle
// inference port; signed Q(W-FRAC).FRAC weights with saturating updates.
module perceptron_array_trainer #(
  parameter int unsigned N_IN      = 2,
  parameter int unsigned N_OUT     = 1,
  parameter int unsigned N_SAMPLES = 4,
  parameter int unsigned W         = 16,
  parameter int unsigned FRAC      = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   clear_weights,
  input  logic [15:0]            epochs,
  input  logic [W-1:0]           learning_rate,
  output logic                   mem_rd,
  output logic [((N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1)-1:0] mem_addr,
  input  logic [N_IN*W-1:0]      mem_x,
  input  logic [N_OUT-1:0]       mem_y,
  output logic                   busy,
  output logic                   done,
  output logic                   converged,
  output logic [15:0]            epoch_errors,
  input  logic                   inf_valid,
  output logic                   inf_ready,
  input  logic [N_IN*W-1:0]      inf_x,
  output logic                   inf_out_valid,
  output logic [N_OUT-1:0]       inf_y
);

  localparam int unsigned AW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam int unsigned SW = 2*W + $clog2(N_IN+1);
  localparam int unsigned UW = 2*W + 2;
  localparam logic signed [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};

  typedef logic [N_IN-1:0][W-1:0]             vec_t;
  typedef logic [N_OUT-1:0][N_IN-1:0][W-1:0]  wmat_t;
  typedef logic [N_OUT-1:0][W-1:0]            bvec_t;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_EVAL, S_UPDATE, S_EPOCH_END} state_t;

  // Full-precision dot product plus shifted bias; a neuron fires when the sum is >= 0.
  function automatic logic [N_OUT-1:0] f_predict(input wmat_t w, input bvec_t b, input vec_t x);
    logic signed [SW-1:0]  v_sum;
    logic signed [2*W-1:0] v_a;
    logic signed [2*W-1:0] v_b;
    logic [N_OUT-1:0]      v_pred;
    v_pred = '0;
    for (int j = 0; j < int'(N_OUT); j++) begin
      v_sum = SW'($signed(b[j])) <<< FRAC;
      for (int i = 0; i < int'(N_IN); i++) begin
        v_a   = (2*W)'($signed(w[j][i]));
        v_b   = (2*W)'($signed(x[i]));
        v_sum = v_sum + SW'(v_a * v_b);
      end
      v_pred[j] = ~v_sum[SW-1];
    end
    return v_pred;
  endfunction

  function automatic logic [W-1:0] f_sat(input logic signed [UW-1:0] t);
    if (t > UW'(S_MAX))      return S_MAX;
    else if (t < UW'(S_MIN)) return S_MIN;
    else                     return W'(t);
  endfunction

  state_t           r_state, w_state_nx;
  wmat_t            r_w, w_w_upd;
  bvec_t            r_b, w_b_upd;
  vec_t             r_x;
  logic [N_OUT-1:0] r_y, r_err_pos, r_err_neg;
  logic [W-1:0]     r_lr;
  logic [15:0]      r_epochs, r_epoch_cnt, r_err_cnt;
  logic [N_OUT-1:0] w_pred_train, w_pred_inf;
  logic             w_last, w_finish, w_mem_rd_nx, w_done_nx, w_busy_nx;

  assign w_pred_train = f_predict(r_w, r_b, r_x);
  assign w_pred_inf   = f_predict(r_w, r_b, vec_t'(inf_x));
  assign w_last       = (mem_addr == AW'(N_SAMPLES - 1));
  assign w_finish     = (r_err_cnt == 16'd0) || (r_epoch_cnt == r_epochs - 16'd1);
  assign inf_ready    = ~busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:      if (start && (epochs != 16'd0)) w_state_nx = S_FETCH;
      S_FETCH:     w_state_nx = S_LOAD;
      S_LOAD:      w_state_nx = S_EVAL;
      S_EVAL:      w_state_nx = S_UPDATE;
      S_UPDATE:    w_state_nx = w_last ? S_EPOCH_END : S_FETCH;
      S_EPOCH_END: w_state_nx = w_finish ? S_IDLE : S_FETCH;
      default:     w_state_nx = S_IDLE;
    endcase
  end

  // Next values of the registered handshake outputs.
  always_comb begin
    w_mem_rd_nx = (w_state_nx == S_FETCH);
    w_done_nx   = 1'b0;
    w_busy_nx   = busy;
    unique case (r_state)
      S_IDLE: if (start) begin
        w_done_nx = (epochs == 16'd0);
        w_busy_nx = (epochs != 16'd0);
      end
      S_EPOCH_END: if (w_finish) begin
        w_done_nx = 1'b1;
        w_busy_nx = 1'b0;
      end
      default: ;
    endcase
  end

  // Saturating weight/bias candidates for the sample held in r_x.
  always_comb begin
    logic signed [2*W-1:0] v_a;
    logic signed [2*W-1:0] v_b;
    logic signed [2*W-1:0] v_delta;
    logic signed [UW-1:0]  v_t;
    v_a = '0; v_b = '0; v_delta = '0; v_t = '0;
    w_w_upd = r_w;
    w_b_upd = r_b;
    for (int j = 0; j < int'(N_OUT); j++) begin
      for (int i = 0; i < int'(N_IN); i++) begin
        v_a     = (2*W)'($signed(r_lr));
        v_b     = (2*W)'($signed(r_x[i]));
        v_delta = (v_a * v_b) >>> FRAC;
        v_t     = UW'($signed(r_w[j][i]));
        if (r_err_pos[j])      v_t = v_t + UW'(v_delta);
        else if (r_err_neg[j]) v_t = v_t - UW'(v_delta);
        w_w_upd[j][i] = f_sat(v_t);
      end
      v_t = UW'($signed(r_b[j]));
      if (r_err_pos[j])      v_t = v_t + UW'($signed(r_lr));
      else if (r_err_neg[j]) v_t = v_t - UW'($signed(r_lr));
      w_b_upd[j] = f_sat(v_t);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w <= '0; r_b <= '0; r_x <= '0; r_y <= '0;
      r_err_pos <= '0; r_err_neg <= '0; r_lr <= '0;
      r_epochs <= '0; r_epoch_cnt <= '0; r_err_cnt <= '0;
      mem_rd <= 1'b0; mem_addr <= '0; busy <= 1'b0; done <= 1'b0;
      converged <= 1'b0; epoch_errors <= '0; inf_out_valid <= 1'b0; inf_y <= '0;
    end else begin
      mem_rd        <= w_mem_rd_nx;
      done          <= w_done_nx;
      busy          <= w_busy_nx;
      inf_out_valid <= inf_valid && !busy;
      if (inf_valid && !busy) inf_y <= w_pred_inf;
      unique case (r_state)
        S_IDLE: begin
          if (clear_weights) begin
            r_w <= '0;
            r_b <= '0;
          end
          if (start) begin
            r_epochs    <= epochs;
            r_lr        <= learning_rate;
            r_epoch_cnt <= '0;
            r_err_cnt   <= '0;
            mem_addr    <= '0;
            converged   <= 1'b0;
            if (epochs == 16'd0) epoch_errors <= '0;
          end
        end
        S_LOAD: begin
          r_x <= vec_t'(mem_x);
          r_y <= mem_y;
        end
        S_EVAL: begin
          r_err_pos <= r_y & ~w_pred_train;
          r_err_neg <= ~r_y & w_pred_train;
          if (r_y != w_pred_train) r_err_cnt <= r_err_cnt + 16'd1;
        end
        S_UPDATE: begin
          r_w <= w_w_upd;
          r_b <= w_b_upd;
          if (!w_last) mem_addr <= mem_addr + AW'(1);
        end
        S_EPOCH_END: begin
          epoch_errors <= r_err_cnt;
          if (w_finish) begin
            converged <= (r_err_cnt == 16'd0);
          end else begin
            r_err_cnt   <= '0;
            mem_addr    <= '0;
            r_epoch_cnt <= r_epoch_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_array_trainer.sv
// Directed bench for perceptron_array_trainer: AND/XOR training, epochs=0,
// saturation, inference blocking during training and reset mid-update.
module tb_perceptron_array_trainer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        clear_weights = 1'b0;
  logic [15:0] epochs = '0;
  logic [15:0] learning_rate = '0;
  logic        mem_rd;
  logic [1:0]  mem_addr;
  logic [31:0] mem_x;
  logic [0:0]  mem_y;
  logic        busy, done, converged;
  logic [15:0] epoch_errors;
  logic        inf_valid = 1'b0;
  logic        inf_ready;
  logic [31:0] inf_x = '0;
  logic        inf_out_valid;
  logic [0:0]  inf_y;

  perceptron_array_trainer #(.N_IN(2), .N_OUT(1), .N_SAMPLES(4), .W(16), .FRAC(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear_weights(clear_weights),
    .epochs(epochs), .learning_rate(learning_rate),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_x(mem_x), .mem_y(mem_y),
    .busy(busy), .done(done), .converged(converged), .epoch_errors(epoch_errors),
    .inf_valid(inf_valid), .inf_ready(inf_ready), .inf_x(inf_x),
    .inf_out_valid(inf_out_valid), .inf_y(inf_y)
  );

  always #5 clk = ~clk;

  // Sample store: data presented for the held address.
  logic [15:0] tx0 [4];
  logic [15:0] tx1 [4];
  logic        ty  [4];
  assign mem_x = {tx1[mem_addr], tx0[mem_addr]};
  assign mem_y = ty[mem_addr];

  typedef struct {
    logic [15:0] x0;
    logic [15:0] x1;
    logic        y;
  } inf_vec_t;
  inf_vec_t iv [13];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_data(input int kind);
    for (int k = 0; k < 4; k++) begin
      case (kind)
        0: begin tx0[k] = k[1] ? 16'd256 : 16'd0; tx1[k] = k[0] ? 16'd256 : 16'd0; ty[k] = k[1] & k[0]; end
        1: begin tx0[k] = k[1] ? 16'd256 : 16'd0; tx1[k] = k[0] ? 16'd256 : 16'd0; ty[k] = k[1] ^ k[0]; end
        2: begin tx0[k] = 16'h7FFF; tx1[k] = 16'h7FFF; ty[k] = 1'b0; end
        default: begin tx0[k] = 16'h7FFF; tx1[k] = 16'h0000; ty[k] = 1'b1; end
      endcase
    end
  endtask

  task automatic infer(input int k);
    @(posedge clk); #1;
    inf_x = {iv[k].x1, iv[k].x0};
    inf_valid = 1'b1;
    @(posedge clk); #1;
    inf_valid = 1'b0;
    chk($sformatf("inf%0d_valid", k), 32'(inf_out_valid), 32'd1);
    chk($sformatf("inf%0d_y", k), 32'(inf_y), 32'(iv[k].y));
  endtask

  task automatic train(input string nm, input logic [15:0] ep, input logic [15:0] lr,
                       input logic clr, input int exp_cyc, input logic exp_conv,
                       input logic [15:0] exp_err, input logic probe);
    int   n, reads, busy_bad, inf_bad;
    logic expb;
    expb = (ep != 16'd0);
    @(posedge clk); #1;
    start = 1'b1; epochs = ep; learning_rate = lr; clear_weights = clr;
    @(posedge clk); #1;
    start = 1'b0; clear_weights = 1'b0;
    inf_x = '0; inf_valid = probe;
    n = 1; reads = 0; busy_bad = 0; inf_bad = 0;
    while (!done && n < 3000) begin
      if (busy !== expb) busy_bad++;
      if (mem_rd) reads++;
      if (probe && (inf_ready !== 1'b0 || inf_out_valid !== 1'b0)) inf_bad++;
      @(posedge clk); #1;
      n++;
    end
    inf_valid = 1'b0;
    chk({nm, "_cycles_to_done"}, 32'(n), 32'(exp_cyc));
    chk({nm, "_busy_profile"}, 32'(busy_bad), 32'd0);
    chk({nm, "_mem_reads"}, 32'(reads), 32'(4 * ((exp_cyc - 1) / 17)));
    if (probe) chk({nm, "_inf_blocked"}, 32'(inf_bad), 32'd0);
    chk({nm, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({nm, "_converged"}, 32'(converged), 32'(exp_conv));
    chk({nm, "_epoch_errors"}, 32'(epoch_errors), 32'(exp_err));
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen_done;
    iv[0]  = '{16'd0,     16'd0,     1'b0};
    iv[1]  = '{16'd0,     16'd256,   1'b0};
    iv[2]  = '{16'd256,   16'd0,     1'b0};
    iv[3]  = '{16'd256,   16'd256,   1'b1};
    iv[4]  = '{16'd0,     16'd0,     1'b1};
    iv[5]  = '{16'd0,     16'd256,   1'b1};
    iv[6]  = '{16'd256,   16'd0,     1'b0};
    iv[7]  = '{16'd256,   16'd256,   1'b0};
    iv[8]  = '{16'h8000,  16'h8000,  1'b1};
    iv[9]  = '{16'd256,   16'd256,   1'b0};
    iv[10] = '{16'd256,   16'd255,   1'b1};
    iv[11] = '{16'd256,   16'd256,   1'b0};
    iv[12] = '{16'd0,     16'd0,     1'b1};
    set_data(0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_converged", 32'(converged), 32'd0);
    chk("rst_epoch_errors", 32'(epoch_errors), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_inf_out_valid", 32'(inf_out_valid), 32'd0);
    chk("rst_inf_y", 32'(inf_y), 32'd0);
    chk("rst_inf_ready", 32'(inf_ready), 32'd1);
    rst_n = 1'b1;

    train("and", 16'd20, 16'd256, 1'b0, 103, 1'b1, 16'd0, 1'b0);
    for (int k = 0; k < 4; k++) infer(k);

    set_data(1);
    train("xor", 16'd5, 16'd256, 1'b1, 86, 1'b0, 16'd4, 1'b1);
    for (int k = 4; k < 8; k++) infer(k);

    train("ep0", 16'd0, 16'd256, 1'b0, 1, 1'b0, 16'd0, 1'b0);
    for (int k = 4; k < 8; k++) infer(k);

    set_data(2);
    train("sat_neg", 16'd3, 16'h7FFF, 1'b1, 35, 1'b1, 16'd0, 1'b0);
    infer(8);
    infer(9);
    set_data(3);
    train("sat_pos", 16'd3, 16'h7FFF, 1'b0, 35, 1'b1, 16'd0, 1'b0);
    infer(10);
    infer(11);

    // Reset lands in the UPDATE of the second sample, after the bias has moved.
    set_data(0);
    @(posedge clk); #1;
    start = 1'b1; epochs = 16'd20; learning_rate = 16'd256; clear_weights = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clear_weights = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("midrst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
    seen_done = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || busy) seen_done++;
    end
    chk("midrst_no_done", 32'(seen_done), 32'd0);
    infer(12);
    train("and_after_rst", 16'd20, 16'd256, 1'b0, 103, 1'b1, 16'd0, 1'b0);
    for (int k = 0; k < 4; k++) infer(k);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
